// File: rtl/mseq_sched_pkg.sv
// Shared types and constants for the M-sequence seed scheduler and datapath top.
package mseq_sched_pkg;

   typedef enum logic [2:0] {
      WARMUP,
      READY,
      LOAD,
      ALIGN,
      RUN
   } sched_state_t;

   localparam int unsigned STAT_W = 32;
   localparam int unsigned LANES  = 16;
   localparam int unsigned LANE_W = 16;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/mseq_sched_cnt.sv
// Loadable up-counter with synchronous clear and terminal-count flag.
// Stops at the terminal value rather than wrapping.
module mseq_sched_cnt #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_clr,
   input  logic             i_ld,
   input  logic [CNT_W-1:0] i_ld_val,
   input  logic [CNT_W-1:0] i_tc_val,
   output logic             o_tc
);

   logic [CNT_W-1:0] r_cnt;
   logic             w_tc;

   assign w_tc = (r_cnt == i_tc_val);
   assign o_tc = w_tc;

   // Clear has priority over load; count only while below terminal value.
   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         r_cnt <= '0;
      end else if (i_ld) begin
         r_cnt <= i_ld_val;
      end else if (!w_tc) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mseq_seed_sched.sv
// Seed scheduler for the M-sequence datapath: managed core warm-up, one-cycle
// seed loads, alignment-latency absorption and output-valid window.
// Optional build macro MSEQ_SCHED_STATS_EN adds frame/underrun statistics ports.
module mseq_seed_sched
   import mseq_sched_pkg::*;
#(
   parameter int unsigned INPUT_DATA_WIDTH = 288,
   parameter int unsigned WARMUP_CYCLES    = 512,
   parameter int unsigned PIPE_LAT         = 3,
   parameter int unsigned RUN_LEN          = 1024,
   parameter int unsigned CNT_W            = 16
) (
   input  logic                        MSEQ_clk,
   input  logic                        MSEQ_rst,
   input  logic [INPUT_DATA_WIDTH-1:0] seed_din,
   input  logic                        seed_vld,
   output logic                        seed_rdy,
   input  logic                        halt,
   output logic [INPUT_DATA_WIDTH-1:0] MSEQ_din,
   output logic                        MSEQ_din_vld,
   output logic                        mseq_core_rst_n,
   output logic                        out_vld,
   output logic                        busy
`ifdef MSEQ_SCHED_STATS_EN
   ,
   output logic [STAT_W-1:0]           stat_frames,
   output logic [STAT_W-1:0]           stat_underrun
`endif
);

   sched_state_t                r_state;
   sched_state_t                w_next;
   logic [INPUT_DATA_WIDTH-1:0] r_din;
   logic [CNT_W-1:0]            w_tc_val;
   logic                        w_tc;
   logic                        w_accept;
   logic                        w_rdy;

   // Ready is a function of state and terminal count only, never of seed_vld.
   assign w_rdy    = (r_state == READY) || ((r_state == RUN) && w_tc);
   assign w_accept = w_rdy && seed_vld;

   // Terminal value for the shared counter depends on the phase being timed.
   always_comb begin
      w_tc_val = '0;
      case (r_state)
         WARMUP:  w_tc_val = CNT_W'(WARMUP_CYCLES - 1);
         ALIGN:   w_tc_val = CNT_W'(PIPE_LAT - 2);
         RUN:     w_tc_val = CNT_W'(RUN_LEN - 1);
         default: w_tc_val = '0;
      endcase
   end

   // Counter restarts at zero on every state change.
   mseq_sched_cnt #(.CNT_W(CNT_W)) u_cnt (
      .i_clk    (MSEQ_clk),
      .i_clr    (MSEQ_rst),
      .i_ld     (r_state != w_next),
      .i_ld_val ('0),
      .i_tc_val (w_tc_val),
      .o_tc     (w_tc)
   );

   // State register.
   always_ff @(posedge MSEQ_clk) begin
      if (MSEQ_rst) begin
         r_state <= WARMUP;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic; on the last RUN cycle an accept outranks halt.
   always_comb begin
      w_next = r_state;
      case (r_state)
         WARMUP: if (w_tc) w_next = READY;
         READY:  if (seed_vld) w_next = LOAD;
         LOAD:   w_next = (PIPE_LAT <= 1) ? RUN : ALIGN;
         ALIGN:  if (w_tc) w_next = RUN;
         RUN: begin
            if (w_tc) begin
               w_next = seed_vld ? LOAD : READY;
            end else if (halt) begin
               w_next = READY;
            end
         end
         default: w_next = WARMUP;
      endcase
   end

   // Seed capture register, cleared by reset and held between accepts.
   always_ff @(posedge MSEQ_clk) begin
      if (MSEQ_rst) begin
         r_din <= '0;
      end else if (w_accept) begin
         r_din <= seed_din;
      end
   end

   // Core reset release coincides with leaving WARMUP, which is only re-entered via MSEQ_rst.
   assign seed_rdy        = w_rdy;
   assign MSEQ_din        = r_din;
   assign MSEQ_din_vld    = (r_state == LOAD);
   assign mseq_core_rst_n = (r_state != WARMUP);
   assign out_vld         = (r_state == RUN);
   assign busy            = (r_state != READY);

`ifdef MSEQ_SCHED_STATS_EN
   logic [STAT_W-1:0] r_frames;
   logic [STAT_W-1:0] r_underrun;
   logic              r_seen;

   // Saturating accept and idle-READY counters; idle counting starts after the first accept.
   always_ff @(posedge MSEQ_clk) begin
      if (MSEQ_rst) begin
         r_frames   <= '0;
         r_underrun <= '0;
         r_seen     <= 1'b0;
      end else begin
         if (w_accept) begin
            r_frames <= sat_inc(r_frames);
            r_seen   <= 1'b1;
         end
         if ((r_state == READY) && !seed_vld && r_seen) begin
            r_underrun <= sat_inc(r_underrun);
         end
      end
   end

   assign stat_frames   = r_frames;
   assign stat_underrun = r_underrun;
`endif

endmodule
